// File: rtl/fifo_action_driver.sv
// Purpose : turns one abstract agent action (idle/push/pop/push+pop for N
//           cycles) into legal push/pop strobes for an attached FIFO, generates
//           sequence-numbered write data, checks read order and FIFO flags.
// Latency : action accepted at edge T -> strobes active T..T+len-1, done in
//           cycle T+len, o_act_ready again in cycle T+len+1.
// Backpressure: o_act_ready is high only in IDLE; blocked ops (full/empty)
//           are skipped for that cycle and counted in o_stall_cnt.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_act_valid/_op/_len, o_act_ready   agent action channel
//   i_fifo_full/_empty/_dataout         FIFO status and head data
//   o_push, o_pop, o_datain             FIFO write/read strobes and write data
//   o_done              one-cycle pulse when an action completes
//   o_occ               modelled FIFO occupancy (0..DEPTH)
//   o_stall_cnt         saturating count of cycles with a blocked op
//   o_mismatch          sticky read-order error
//   o_flag_err          sticky FIFO flag vs. occupancy disagreement
module fifo_action_driver #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int LENW  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_act_valid,
   output logic                       o_act_ready,
   input  logic [1:0]                 i_act_op,
   input  logic [LENW-1:0]            i_act_len,
   input  logic                       i_fifo_full,
   input  logic                       i_fifo_empty,
   input  logic [WIDTH-1:0]           i_fifo_dataout,
   output logic                       o_push,
   output logic                       o_pop,
   output logic [WIDTH-1:0]           o_datain,
   output logic                       o_done,
   output logic [$clog2(DEPTH):0]     o_occ,
   output logic [7:0]                 o_stall_cnt,
   output logic                       o_mismatch,
   output logic                       o_flag_err
);

   localparam int OCCW = $clog2(DEPTH) + 1;
   localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [1:0]        r_op;
   logic [LENW-1:0]   r_rem;
   logic [OCCW-1:0]   r_occ;
   logic [WIDTH-1:0]  r_wr_seq;
   logic [WIDTH-1:0]  r_rd_seq;
   logic [7:0]        r_stall_cnt;
   logic              r_mismatch;
   logic              r_flag_err;

   logic              w_accept;
   logic              w_run;
   logic              w_push;
   logic              w_pop;
   logic              w_stall;
   logic              w_flag_bad;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      o_act_ready = 1'b0;
      o_done      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_act_ready = 1'b1;
            if (i_act_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // rem never reaches 0 in RUN (len is clamped to >=1), but treat
            // it like 1 so a corrupted count can never lock the FSM in RUN.
            if (r_rem <= LENW'(1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Strobes. Derived only from our own occupancy model: the FIFO flags
   // are combinational in push/pop, so using them here would form a loop.
   // A pop frees the slot a simultaneous push needs, so push-on-full is
   // legal only alongside a pop. Pop-on-empty is never legal.
   // ------------------------------------------------------------------
   always_comb begin
      w_run  = (r_state == ST_RUN);
      w_pop  = w_run & r_op[1] & (r_occ != '0);
      w_push = w_run & r_op[0] & ((r_occ < OCC_FULL) | w_pop);
      // A requested op that did not issue this cycle is a stall.
      w_stall = w_run & ((r_op[0] & ~w_push) | (r_op[1] & ~w_pop));
      // Flags are only meaningful against occ when no strobe is in flight,
      // since the FIFO's flags react combinationally to push/pop.
      w_flag_bad = ~w_push & ~w_pop &
                   ((i_fifo_full  != (r_occ == OCC_FULL)) |
                    (i_fifo_empty != (r_occ == '0)));
   end

   // ------------------------------------------------------------------
   // Latched action: op and remaining cycle count
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op  <= 2'b00;
         r_rem <= '0;
      end else if (w_accept) begin
         r_op  <= i_act_op;
         r_rem <= (i_act_len == '0) ? LENW'(1) : i_act_len;
      end else if (w_run) begin
         r_rem <= r_rem - LENW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Occupancy model: simultaneous push+pop leaves it unchanged
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCCW'(1);
            2'b01:   r_occ <= r_occ - OCCW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Write/read sequence numbers; both wrap naturally at 2^WIDTH
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_seq <= '0;
         r_rd_seq <= '0;
      end else begin
         if (w_push) begin
            r_wr_seq <= r_wr_seq + WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_seq <= r_rd_seq + WIDTH'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stall counter, saturating at 255
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 8'd0;
      end else if (w_stall && (r_stall_cnt != 8'hFF)) begin
         r_stall_cnt <= r_stall_cnt + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mismatch <= 1'b0;
         r_flag_err <= 1'b0;
      end else begin
         // The head data must carry the next expected read sequence number.
         if (w_pop && (i_fifo_dataout != r_rd_seq)) begin
            r_mismatch <= 1'b1;
         end
         if (w_flag_bad) begin
            r_flag_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_push      = w_push;
   assign o_pop       = w_pop;
   assign o_datain    = r_wr_seq;
   assign o_occ       = r_occ;
   assign o_stall_cnt = r_stall_cnt;
   assign o_mismatch  = r_mismatch;
   assign o_flag_err  = r_flag_err;

endmodule

// File: tb/tb_fifo_action_driver.sv
module tb_fifo_action_driver;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int LENW  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             act_valid = 1'b0;
   logic             act_ready;
   logic [1:0]       act_op = 2'b00;
   logic [LENW-1:0]  act_len = '0;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dataout;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] datain;
   logic             done;
   logic [3:0]       occ;
   logic [7:0]       stall_cnt;
   logic             mismatch;
   logic             flag_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural FIFO attached to the driver, with fault-injection overrides
   logic [WIDTH-1:0] q[$];
   logic             f_full  = 1'b0;
   logic             f_empty = 1'b1;
   logic [WIDTH-1:0] f_head  = '0;
   logic             inj_bad = 1'b0;
   logic             inj_empty_low = 1'b0;

   assign fifo_full    = f_full;
   assign fifo_empty   = f_empty & ~inj_empty_low;
   assign fifo_dataout = f_head ^ {WIDTH{inj_bad}};

   // Reference model of the driver, tracked per action
   int m_occ, m_wr, m_rd, m_stall;
   bit m_mis, m_flag;

   always #5 clk = ~clk;

   fifo_action_driver #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LENW(LENW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_act_valid    (act_valid),
      .o_act_ready    (act_ready),
      .i_act_op       (act_op),
      .i_act_len      (act_len),
      .i_fifo_full    (fifo_full),
      .i_fifo_empty   (fifo_empty),
      .i_fifo_dataout (fifo_dataout),
      .o_push         (push),
      .o_pop          (pop),
      .o_datain       (datain),
      .o_done         (done),
      .o_occ          (occ),
      .o_stall_cnt    (stall_cnt),
      .o_mismatch     (mismatch),
      .o_flag_err     (flag_err)
   );

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (pop && q.size() > 0) void'(q.pop_front());
         if (push && q.size() < DEPTH) q.push_back(datain);
      end
      f_full  <= (q.size() == DEPTH);
      f_empty <= (q.size() == 0);
      f_head  <= (q.size() > 0) ? q[0] : '0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_occ = 0; m_wr = 0; m_rd = 0; m_stall = 0; m_mis = 0; m_flag = 0;
      inj_bad = 1'b0; inj_empty_low = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      act_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // Offer one action from IDLE and check every cycle until act_ready returns.
   task automatic run_action(input logic [1:0] op, input int len, input bit bad);
      int  eff;
      bit  e_push, e_pop;
      eff = (len == 0) ? 1 : len;
      chk("ready_before", act_ready, 1);
      act_valid = 1'b1;
      act_op    = op;
      act_len   = LENW'(len);
      @(negedge clk);
      for (int i = 0; i < eff; i++) begin
         // junk on the action channel must be ignored while busy
         act_valid = 1'($urandom_range(0, 1));
         act_op    = 2'($urandom_range(0, 3));
         act_len   = LENW'($urandom_range(0, 15));
         e_pop  = op[1] && (m_occ > 0);
         e_push = op[0] && ((m_occ < DEPTH) || e_pop);
         inj_bad = bad && e_pop;
         chk("push", push, e_push);
         chk("pop", pop, e_pop);
         chk("occ_run", occ, m_occ);
         chk("ready_run", act_ready, 0);
         chk("done_run", done, 0);
         if (e_push) chk("datain", datain, m_wr);
         if (e_pop) begin
            if (bad) m_mis = 1;
            m_rd = (m_rd + 1) % 256;
         end
         if (e_push) m_wr = (m_wr + 1) % 256;
         m_occ = m_occ + int'(e_push) - int'(e_pop);
         if ((op[0] && !e_push) || (op[1] && !e_pop))
            m_stall = (m_stall < 255) ? m_stall + 1 : 255;
         @(negedge clk);
      end
      inj_bad   = 1'b0;
      act_valid = 1'b0;
      chk("done_pulse", done, 1);
      chk("ready_done", act_ready, 0);
      chk("push_done", push, 0);
      chk("pop_done", pop, 0);
      chk("occ_done", occ, m_occ);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("mismatch", mismatch, m_mis);
      chk("flag_err", flag_err, m_flag);
      @(negedge clk);
      chk("ready_after", act_ready, 1);
      chk("done_after", done, 0);
   endtask

   task automatic idle_cycle();
      act_valid = 1'b0;
      chk("idle_push", push, 0);
      chk("idle_pop", pop, 0);
      chk("idle_ready", act_ready, 1);
      chk("idle_flag_err", flag_err, m_flag);
      @(negedge clk);
   endtask

   initial begin
      model_clear();
      do_reset();
      // reset state
      chk("rst_ready", act_ready, 1);
      chk("rst_push", push, 0);
      chk("rst_pop", pop, 0);
      chk("rst_datain", datain, 0);
      chk("rst_done", done, 0);
      chk("rst_occ", occ, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_mismatch", mismatch, 0);
      chk("rst_flag_err", flag_err, 0);

      // fill to full, then blocked pushes, then push+pop on full
      run_action(2'b01, 8, 0);
      chk("tp_fill_occ", occ, 8);
      chk("tp_fill_stall", stall_cnt, 0);
      idle_cycle();
      run_action(2'b01, 3, 0);
      chk("tp_block_stall", stall_cnt, 3);
      chk("tp_block_occ", occ, 8);
      run_action(2'b11, 4, 0);
      chk("tp_pp_occ", occ, 8);
      chk("tp_pp_datain", datain, 12);
      chk("tp_pp_mismatch", mismatch, 0);

      // drain, then pop on empty and push+pop on empty
      run_action(2'b10, 8, 0);
      chk("tp_drain_occ", occ, 0);
      run_action(2'b10, 2, 0);
      run_action(2'b11, 2, 0);
      chk("tp_empty_occ", occ, 1);
      chk("tp_empty_stall", stall_cnt, 6);

      // corrupt popped data once; mismatch must stick
      run_action(2'b10, 1, 1);
      idle_cycle();
      idle_cycle();
      chk("tp_mismatch_sticky", mismatch, 1);

      // lie about empty while occ==0
      inj_empty_low = 1'b1;
      m_flag = 1;
      @(negedge clk);
      inj_empty_low = 1'b0;
      chk("tp_flag_err", flag_err, 1);
      idle_cycle();

      // len=0 behaves as len=1
      run_action(2'b01, 0, 0);

      // stall counter saturation
      run_action(2'b01, 8, 0);
      for (int i = 0; i < 18; i++) run_action(2'b01, 15, 0);
      chk("tp_stall_sat", stall_cnt, 255);

      // reset in the middle of push len=10
      act_valid = 1'b1; act_op = 2'b01; act_len = 4'd10;
      @(negedge clk);
      act_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", act_ready, 1);
      chk("mid_rst_occ", occ, 0);
      chk("mid_rst_push", push, 0);
      chk("mid_rst_mismatch", mismatch, 0);
      rst = 1'b0;
      model_clear();
      chk("mid_rst_datain", datain, 0);
      run_action(2'b01, 1, 0);
      chk("mid_rst_occ_after", occ, 1);

      // randomized actions with idle gaps; long enough to wrap the sequences
      for (int n = 0; n < 220; n++) begin
         int gaps;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) idle_cycle();
         run_action(2'($urandom_range(0, 3)), $urandom_range(0, 15), 0);
      end
      chk("rand_mismatch", mismatch, 0);
      chk("rand_flag_err", flag_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
